// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues word reads to instruction memory,
// captures the returned word into the IR and decodes the RISC-V base fields.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic        pc_inc,
  input  logic        pc_load,
  input  logic [31:0] pc_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  funct7,
  output logic        ir_valid,
  output logic        fetch_done,
  output logic        busy,
  output logic        fetch_err
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  // Next-state, PC update, IR capture and registered-output decode
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    cnt_d      = cnt_q;

    // PC moves only while no fetch is in flight; load wins over increment
    if (state_q == IDLE || state_q == ERR) begin
      if (pc_load) begin
        pc_d = pc_target;
      end else if (pc_inc) begin
        pc_d = pc_q + XLEN'(4);
      end
    end

    case (state_q)
      IDLE, ERR: begin
        // Alignment is judged on the PC as updated in this same cycle
        if (fetch_start) begin
          ir_valid_d = 1'b0;
          cnt_d      = '0;
          state_d    = (pc_d[1:0] == 2'b00) ? REQ : ERR;
        end
      end
      REQ: begin
        if (imem_ack) begin
          ir_d       = imem_rdata;
          ir_valid_d = 1'b1;
          state_d    = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_d  = (state_d == REQ);
    busy_d = (state_d == REQ) || (state_d == DONE);
    done_d = (state_d == DONE);
    err_d  = (state_d == ERR);
  end

  // State and output registers; reset takes effect without a clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= NOP;
      ir_valid_q <= 1'b0;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // PC cannot change while busy, so it doubles as a stable request address
  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign ir         = ir_q;
  assign ir_valid   = ir_valid_q;
  assign fetch_done = done_q;
  assign busy       = busy_q;
  assign fetch_err  = err_q;

  // Instruction field decode
  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign funct7 = ir_q[31:25];

endmodule
